// File: rtl/vga_ctrl.sv
// vga_ctrl: 640x480@60Hz monochrome VGA timing and scan-out engine.
//
// Reads the frame memory over a synchronous read port (data valid one clock
// after the address) and expands each 32-bit word into 32 one-bit pixels,
// driven as 12-bit RGB. Everything runs on the pixel clock.
//
// Ports
//   clock        in   1   pixel clock (25 MHz nominal)
//   reset_n      in   1   asynchronous active-low reset
//   address_b    out  14  frame-memory word address (combinational from counters)
//   q_b          in   32  frame-memory read data, valid 1 clk after address_b
//   vga_hsync    out  1   horizontal sync, active low
//   vga_vsync    out  1   vertical sync, active low
//   vga_r/g/b    out  4   colour outputs, 0 outside the visible area
//   frame_start  out  1   one-clock pulse aligned with output pixel (0,0)
//   pattern_sel  in   1   only with VGA_CTRL_PATTERN_EN: 1 selects a 16x16
//                         checkerboard instead of memory data
//
// Optional feature macro: VGA_CTRL_PATTERN_EN.
//
// Pipeline: stage 0 = counters + address, stage 1 = memory data arrives with
// delayed control, stage 2 = output registers. All outputs have a fixed
// two-clock latency relative to the counters, so they stay mutually aligned.
module vga_ctrl #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [13:0] address_b,
  input  logic [31:0] q_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
`ifdef VGA_CTRL_PATTERN_EN
  ,
  input  logic        pattern_sel
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [13:0] WORDS_PER_LINE = 14'(H_VISIBLE / 32);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]  HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]  HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  // ---------------- stage 0: counters ----------------
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [13:0] line_base_q, line_base_d;
  logic        h_wrap, v_wrap;

  always_comb begin
    h_wrap      = (h_cnt_q == H_LAST);
    v_wrap      = (v_cnt_q == V_LAST);
    h_cnt_d     = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d     = v_cnt_q;
    line_base_d = line_base_q;
    if (h_wrap) begin
      if (v_wrap) begin
        v_cnt_d     = 10'd0;
        line_base_d = 14'd0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
        // Row start address advances by accumulation, so no multiplier.
        if (v_cnt_q < V_VIS) line_base_d = line_base_q + WORDS_PER_LINE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q     <= 10'd0;
      v_cnt_q     <= 10'd0;
      line_base_q <= 14'd0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      line_base_q <= line_base_d;
    end
  end

  // ---------------- stage 0: decode ----------------
  logic visible_0, hsync_0, vsync_0, frame_0, pattern_0, checker_0;

  always_comb begin
    visible_0 = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hsync_0   = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    vsync_0   = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    frame_0   = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    checker_0 = h_cnt_q[4] ^ v_cnt_q[4];
`ifdef VGA_CTRL_PATTERN_EN
    pattern_0 = pattern_sel;
`else
    pattern_0 = 1'b0;
`endif
    // Blanking parks the address at 0; the returned data is then ignored.
    address_b = visible_0 ? (line_base_q + {9'd0, h_cnt_q[9:5]}) : 14'd0;
  end

  // ---------------- stage 1: data arrives ----------------
  logic [4:0] h_d1_q;
  logic       visible_d1_q, hsync_d1_q, vsync_d1_q, frame_d1_q;
  logic       pattern_d1_q, checker_d1_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_d1_q       <= 5'd0;
      visible_d1_q <= 1'b0;
      hsync_d1_q   <= 1'b1;
      vsync_d1_q   <= 1'b1;
      frame_d1_q   <= 1'b0;
      pattern_d1_q <= 1'b0;
      checker_d1_q <= 1'b0;
    end else begin
      h_d1_q       <= h_cnt_q[4:0];
      visible_d1_q <= visible_0;
      hsync_d1_q   <= hsync_0;
      vsync_d1_q   <= vsync_0;
      frame_d1_q   <= frame_0;
      pattern_d1_q <= pattern_0;
      checker_d1_q <= checker_0;
    end
  end

  // ---------------- stage 2: output registers ----------------
  logic        pixel_1;
  logic [11:0] rgb_d, rgb_q;
  logic        hsync_q, vsync_q, frame_q;

  always_comb begin
    // Bit 0 of a word is the leftmost pixel of its 32-pixel group.
    pixel_1 = pattern_d1_q ? checker_d1_q : q_b[h_d1_q];
    rgb_d   = visible_d1_q ? (pixel_1 ? FG_COLOR : BG_COLOR) : 12'h000;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q   <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d1_q;
      vsync_q <= vsync_d1_q;
      frame_q <= frame_d1_q;
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign frame_start = frame_q;

endmodule
